// File: rtl/fight_pkg.sv
// fight_pkg -- shared definitions for the fight sequencer slice.
//   fight_state_t : FSM state encoding (IDLE=0 .. MATCH_OVER=4)
//   winner_t      : winner encoding (00 none, 01 P1, 10 P2, 11 draw)
//   DEF_*         : default timing constants
//   cnt_w()       : counter width helper (never below 1 bit)
//   round_result(): round decision from the two health values
//   match_result(): match decision from the two win counters
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INTRO      = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_MATCH_OVER = 3'd4
  } fight_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam int DEF_CLK_HZ        = 100_000_000;
  localparam int DEF_TICK_HZ       = 20;
  localparam int DEF_ROUND_SECONDS = 60;
  localparam int DEF_INTRO_TICKS   = 60;
  localparam int DEF_KO_TICKS      = 40;
  localparam int DEF_WINS_NEEDED   = 2;
  localparam int DEF_MAX_ROUNDS    = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Only meaningful when the round is ending: a KO decides first (double KO
  // is a draw), otherwise the timeout goes to the healthier player.
  function automatic winner_t round_result(input logic [6:0] p1, input logic [6:0] p2);
    if (p1 == '0 && p2 == '0) return WIN_DRAW;
    if (p1 == '0)             return WIN_P2;
    if (p2 == '0)             return WIN_P1;
    if (p1 > p2)              return WIN_P1;
    if (p2 > p1)              return WIN_P2;
    return WIN_DRAW;
  endfunction

  function automatic winner_t match_result(input logic [1:0] w1, input logic [1:0] w2);
    if (w1 > w2) return WIN_P1;
    if (w2 > w1) return WIN_P2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/fight_sequencer_if.sv
// fight_sequencer_if -- game-side signal bundle of the fight sequencer.
//   master : the sequencer (takes start/health, drives timing and status)
//   slave  : the game logic / physics side
//   start, p1_health, p2_health           : game -> sequencer
//   tick, phys_tick, phys_reset, input_en : timing / control outputs
//   state, round_time, round_no, p1_wins, p2_wins, winner, match_over : status
interface fight_sequencer_if;
  import fight_pkg::*;

  logic         start;
  logic [6:0]   p1_health;
  logic [6:0]   p2_health;
  logic         tick;
  logic         phys_tick;
  logic         phys_reset;
  logic         input_en;
  fight_state_t state;
  logic [6:0]   round_time;
  logic [1:0]   round_no;
  logic [1:0]   p1_wins;
  logic [1:0]   p2_wins;
  winner_t      winner;
  logic         match_over;

  modport master (
    input  start, p1_health, p2_health,
    output tick, phys_tick, phys_reset, input_en, state, round_time,
           round_no, p1_wins, p2_wins, winner, match_over
  );

  modport slave (
    output start, p1_health, p2_health,
    input  tick, phys_tick, phys_reset, input_en, state, round_time,
           round_no, p1_wins, p2_wins, winner, match_over
  );

endinterface

// File: rtl/tick_divider.sv
// tick_divider -- free-running clock divider plus a tick sub-counter.
//   clk, reset : clock, synchronous active-high reset
//   sub_clr    : clears the sub-counter (used when a fight starts)
//   tick       : one-cycle pulse every DIV cycles
//   sub_cnt    : ticks seen modulo SUB_N (0..SUB_N-1)
module tick_divider
  import fight_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int SUB_N = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sub_clr,
  output logic                    tick,
  output logic [cnt_w(SUB_N)-1:0] sub_cnt
);

  localparam int CW = cnt_w(DIV);
  localparam int SW = cnt_w(SUB_N);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sub_clr) begin
      sub_cnt <= '0;
    end else if (tick) begin
      sub_cnt <= (sub_cnt == SW'(SUB_N - 1)) ? '0 : sub_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fight_sequencer.sv
// fight_sequencer -- round/match sequencer for a two-player fighting game.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fight_sequencer_if.master (start/health in, timing and
//                status out; see the interface file for the signal list)
// Flow: IDLE -> INTRO -> FIGHT -> KO -> (INTRO | MATCH_OVER).
module fight_sequencer
  import fight_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int TICK_HZ       = DEF_TICK_HZ,
  parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
  parameter int INTRO_TICKS   = DEF_INTRO_TICKS,
  parameter int KO_TICKS      = DEF_KO_TICKS,
  parameter int WINS_NEEDED   = DEF_WINS_NEEDED,
  parameter int MAX_ROUNDS    = DEF_MAX_ROUNDS
) (
  input  logic              clk,
  input  logic              reset,
  fight_sequencer_if.master bus
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int SW   = cnt_w(TICK_HZ);
  localparam int PH_N = (INTRO_TICKS > KO_TICKS) ? INTRO_TICKS : KO_TICKS;
  localparam int PW   = cnt_w(PH_N);

  logic          tick;
  logic          sub_clr;
  logic [SW-1:0] sub_cnt;

  fight_state_t  state_q, state_d;
  logic [PW-1:0] phase_q;        // ticks spent in INTRO / KO
  logic [6:0]    round_time_q;
  logic [1:0]    round_no_q;
  logic [1:0]    p1_wins_q, p2_wins_q;
  winner_t       winner_q, round_res;

  logic end_now, sec_done, match_done;
  logic match_start, next_round, to_over;

  tick_divider #(.DIV(DIV), .SUB_N(TICK_HZ)) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .sub_clr(sub_clr),
    .tick   (tick),
    .sub_cnt(sub_cnt)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    sub_clr        = 1'b0;
    match_start    = 1'b0;
    next_round     = 1'b0;
    to_over        = 1'b0;
    bus.phys_reset = 1'b0;
    bus.phys_tick  = 1'b0;
    bus.input_en   = 1'b0;
    bus.match_over = 1'b0;

    round_res  = round_result(bus.p1_health, bus.p2_health);
    // Health and the timer are only looked at on tick cycles of a fight.
    end_now    = (state_q == ST_FIGHT) && tick &&
                 (bus.p1_health == '0 || bus.p2_health == '0 || round_time_q == '0);
    sec_done   = (state_q == ST_FIGHT) && tick && !end_now &&
                 (sub_cnt == SW'(TICK_HZ - 1)) && (round_time_q != '0);
    match_done = (p1_wins_q == 2'(WINS_NEEDED)) || (p2_wins_q == 2'(WINS_NEEDED)) ||
                 (round_no_q == 2'(MAX_ROUNDS));

    case (state_q)
      ST_IDLE: begin
        bus.phys_reset = 1'b1;
        if (bus.start) begin
          state_d     = ST_INTRO;
          match_start = 1'b1;
        end
      end
      ST_INTRO: begin
        bus.phys_reset = 1'b1;
        if (tick && phase_q == PW'(INTRO_TICKS - 1)) begin
          state_d = ST_FIGHT;
          sub_clr = 1'b1;
        end
      end
      ST_FIGHT: begin
        bus.phys_tick = tick;
        bus.input_en  = 1'b1;
        if (end_now) state_d = ST_KO;
      end
      ST_KO: begin
        if (tick && phase_q == PW'(KO_TICKS - 1)) begin
          if (match_done) begin
            state_d = ST_MATCH_OVER;
            to_over = 1'b1;
          end else begin
            state_d    = ST_INTRO;
            next_round = 1'b1;
          end
        end
      end
      ST_MATCH_OVER: begin
        bus.match_over = 1'b1;
        if (bus.start) begin
          state_d     = ST_INTRO;
          match_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      round_time_q <= 7'(ROUND_SECONDS);
      round_no_q   <= '0;
      p1_wins_q    <= '0;
      p2_wins_q    <= '0;
      winner_q     <= WIN_NONE;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        phase_q <= '0;
      end else if (tick && (state_q == ST_INTRO || state_q == ST_KO)) begin
        phase_q <= phase_q + 1'b1;
      end

      if (state_d == ST_INTRO && state_q != ST_INTRO) begin
        round_time_q <= 7'(ROUND_SECONDS);
      end else if (sec_done) begin
        round_time_q <= round_time_q - 7'd1;
      end

      if (match_start) begin
        round_no_q <= 2'd1;
        p1_wins_q  <= '0;
        p2_wins_q  <= '0;
        winner_q   <= WIN_NONE;
      end

      if (end_now) begin
        winner_q <= round_res;
        if (round_res == WIN_P1 && p1_wins_q != 2'd3) p1_wins_q <= p1_wins_q + 2'd1;
        if (round_res == WIN_P2 && p2_wins_q != 2'd3) p2_wins_q <= p2_wins_q + 2'd1;
      end

      // next_round only fires while round_no < MAX_ROUNDS (match_done guards it).
      if (next_round) begin
        round_no_q <= round_no_q + 2'd1;
        winner_q   <= WIN_NONE;
      end

      if (to_over) winner_q <= match_result(p1_wins_q, p2_wins_q);
    end
  end

  assign bus.tick       = tick;
  assign bus.state      = state_q;
  assign bus.round_time = round_time_q;
  assign bus.round_no   = round_no_q;
  assign bus.p1_wins    = p1_wins_q;
  assign bus.p2_wins    = p2_wins_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_fight_sequencer.sv
// tb_fight_sequencer -- directed scenarios plus a random soak, every cycle
// compared against an event-level model of the round/match rules.
module tb_fight_sequencer;
  import fight_pkg::*;

  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 20;
  localparam int RS      = 3;
  localparam int IT      = 2;
  localparam int KT      = 2;
  localparam int WN      = 2;
  localparam int MR      = 3;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  localparam int S_IDLE = 0, S_INTRO = 1, S_FIGHT = 2, S_KO = 3, S_OVER = 4;

  logic clk = 1'b0;
  logic reset;

  fight_sequencer_if bus ();

  fight_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ROUND_SECONDS(RS),
    .INTRO_TICKS(IT), .KO_TICKS(KT), .WINS_NEEDED(WN), .MAX_ROUNDS(MR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase lengths counted in ticks, round timer derived
  // from the number of fight ticks elapsed.
  int m_state, m_n, m_tick, m_phase, m_fticks, m_rt, m_round, m_w1, m_w2, m_winner;

  function automatic int decide(input int a, input int b);
    if (a == 0 && b == 0) return 3;
    if (a == 0) return 2;
    if (b == 0) return 1;
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    int n;
    int tk;
    if (reset) begin
      m_state = S_IDLE; m_n = 0; m_tick = 0; m_phase = 0; m_fticks = 0;
      m_rt = RS; m_round = 0; m_w1 = 0; m_w2 = 0; m_winner = 0;
      return;
    end
    n  = m_n + 1;
    tk = m_tick;
    case (m_state)
      S_IDLE, S_OVER: if (bus.start) begin
        m_state = S_INTRO; m_round = 1; m_w1 = 0; m_w2 = 0; m_winner = 0;
        m_rt = RS; m_phase = 0;
      end
      S_INTRO: if (tk != 0) begin
        m_phase++;
        if (m_phase == IT) begin m_state = S_FIGHT; m_fticks = 0; end
      end
      S_FIGHT: if (tk != 0) begin
        if (bus.p1_health == 0 || bus.p2_health == 0 || m_rt == 0) begin
          m_winner = decide(int'(bus.p1_health), int'(bus.p2_health));
          if (m_winner == 1 && m_w1 < 3) m_w1++;
          if (m_winner == 2 && m_w2 < 3) m_w2++;
          m_state = S_KO; m_phase = 0;
        end else begin
          m_fticks++;
          m_rt = RS - m_fticks / TICK_HZ;
          if (m_rt < 0) m_rt = 0;
        end
      end
      S_KO: if (tk != 0) begin
        m_phase++;
        if (m_phase == KT) begin
          if (m_w1 == WN || m_w2 == WN || m_round == MR) begin
            m_state  = S_OVER;
            m_winner = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
          end else begin
            m_state = S_INTRO; m_round++; m_winner = 0; m_rt = RS; m_phase = 0;
          end
        end
      end
      default: ;
    endcase
    m_n    = n;
    m_tick = (n % DIV == 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("state",      bus.state,      m_state);
    check("tick",       bus.tick,       m_tick);
    check("phys_tick",  bus.phys_tick,  (m_state == S_FIGHT && m_tick != 0) ? 1 : 0);
    check("phys_reset", bus.phys_reset, (m_state == S_IDLE || m_state == S_INTRO) ? 1 : 0);
    check("input_en",   bus.input_en,   (m_state == S_FIGHT) ? 1 : 0);
    check("round_time", bus.round_time, m_rt);
    check("round_no",   bus.round_no,   m_round);
    check("p1_wins",    bus.p1_wins,    m_w1);
    check("p2_wins",    bus.p2_wins,    m_w2);
    check("winner",     bus.winner,     m_winner);
    check("match_over", bus.match_over, (m_state == S_OVER) ? 1 : 0);
  endtask

  // Inputs change only between edges; outputs are sampled 1 time unit after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int i = 0;
    while (m_state != st && i < budget) begin
      step();
      i++;
    end
    check(tag, bus.state, st);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic fight_then(input int p1_end, input int p2_end, input string tag);
    wait_state(S_FIGHT, 20, {tag, "_fight"});
    repeat ($urandom_range(3, 40)) step();
    bus.p1_health = 7'(p1_end);
    bus.p2_health = 7'(p2_end);
    wait_state(S_KO, 4, {tag, "_ko"});
    bus.p1_health = 7'($urandom_range(1, 127));
    bus.p2_health = 7'($urandom_range(1, 127));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.p1_health = 7'd50;
    bus.p2_health = 7'd50;
    repeat (3) step();
    check("rst_state",      bus.state,      S_IDLE);
    check("rst_phys_reset", bus.phys_reset, 1);
    check("rst_round_time", bus.round_time, RS);
    reset = 1'b0;

    // Match 1: timeout draw, P1 KO win, P2 KO win -> even wins at round cap.
    pulse_start();
    check("start_intro", bus.state,    S_INTRO);
    check("start_round", bus.round_no, 1);
    wait_state(S_FIGHT, 10, "enter_fight");
    wait_state(S_KO, 200, "timeout_ko");
    check("timeout_winner", bus.winner,  3);
    check("timeout_wins",   bus.p1_wins, 0);
    wait_state(S_INTRO, 10, "round2_intro");
    check("round2_no", bus.round_no, 2);
    fight_then(50, 0, "r2");
    check("r2_winner", bus.winner,  1);
    check("r2_p1wins", bus.p1_wins, 1);
    fight_then(0, 60, "r3");
    check("r3_winner", bus.winner, 2);
    wait_state(S_OVER, 10, "even_over");
    check("even_winner", bus.winner,   3);
    check("even_round",  bus.round_no, 3);

    // Match 2: P1 takes two rounds, round 3 never starts.
    pulse_start();
    fight_then(70, 0, "m2r1");
    fight_then(20, 0, "m2r2");
    wait_state(S_OVER, 10, "p1_over");
    check("p1_over_winner", bus.winner,     1);
    check("p1_over_round",  bus.round_no,   2);
    check("p1_over_flag",   bus.match_over, 1);
    repeat (10) step();

    // Match 3: three double KOs.
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      fight_then(0, 0, "draw");
      check("draw_winner", bus.winner, 3);
    end
    wait_state(S_OVER, 10, "draw_over");
    check("draw_over_winner", bus.winner,   3);
    check("draw_over_round",  bus.round_no, 3);

    // Match 4: start held mid-fight is ignored, then reset aborts the round.
    pulse_start();
    fight_then(40, 0, "m4r1");
    wait_state(S_FIGHT, 20, "m4r2_fight");
    bus.start = 1'b1;
    repeat (30) step();
    check("start_ignored", bus.state, S_FIGHT);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b0;
    check("abort_state",      bus.state,      S_IDLE);
    check("abort_phys_reset", bus.phys_reset, 1);
    check("abort_p1wins",     bus.p1_wins,    0);

    // Random soak.
    for (int c = 0; c < 4000; c++) begin
      bus.start = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 7) == 0)   bus.p1_health = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0)   bus.p2_health = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 149) == 0) bus.p1_health = 7'd0;
      if ($urandom_range(0, 149) == 0) bus.p2_health = 7'd0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fight_sequencer.md
FIGHT_SEQUENCER -- requirements
Module: fight_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CLK_HZ, 100000000, system clock frequency
- TICK_HZ, 20, game tick rate
- ROUND_SECONDS, 60, round timer load value (1..99)
- INTRO_TICKS, 60, pre-fight hold length in ticks
- KO_TICKS, 40, post-round hold length in ticks
- WINS_NEEDED, 2, round wins that end the match
- MAX_ROUNDS, 3, round cap (1..3)
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high
- start, in, 1, level; starts a match from IDLE or MATCH_OVER
- p1_health, in, 7, player-1 health (0 = KO)
- p2_health, in, 7, player-2 health (0 = KO)
- tick, out, 1, free-running one-cycle pulse at TICK_HZ
- phys_tick, out, 1, physics-engine clock enable
- phys_reset, out, 1, holds physics engines at spawn positions
- input_en, out, 1, gates player controls
- state, out, 3, current FSM state
- round_time, out, 7, seconds remaining
- round_no, out, 2, current round, 1-based
- p1_wins, out, 2, rounds won by player 1
- p2_wins, out, 2, rounds won by player 2
- winner, out, 2, 00 none, 01 P1, 10 P2, 11 draw
- match_over, out, 1, high in MATCH_OVER

Function
REQ-003 tick SHALL pulse for one cycle every CLK_HZ/TICK_HZ cycles, from a divider counting 0..CLK_HZ/TICK_HZ-1 that runs in every state.
REQ-004 FSM states SHALL be IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_OVER=4; all transitions are registered.
REQ-005 IDLE SHALL assert phys_reset, deassert phys_tick and input_en, and on start go to INTRO with round_no=1, wins cleared, and winner=00.
REQ-006 INTRO SHALL assert phys_reset, hold round_time=ROUND_SECONDS, count INTRO_TICKS ticks, then go to FIGHT and clear the seconds sub-counter.
REQ-007 FIGHT: phys_tick=tick, input_en=1, phys_reset=0.
REQ-008 FIGHT SHALL decrement round_time on every TICK_HZ-th tick while round_time>0, saturating at 0.
REQ-009 FIGHT SHALL evaluate the end condition only on tick cycles: either health==0 or round_time==0.
- Decision, in priority order: both health 0 -> draw; p1_health 0 -> P2; p2_health 0 -> P1; timeout -> higher health wins, equal -> draw.
REQ-010 On that evaluation the FSM SHALL enter KO and, in the same registered update, increment the round winner's win counter (none for a draw) and set winner to the round result.
REQ-011 KO SHALL hold phys_tick=0 and input_en=0 for KO_TICKS ticks.
- Then, if either win counter equals WINS_NEEDED or round_no equals MAX_ROUNDS -> MATCH_OVER.
- Otherwise -> INTRO with round_no+1 and winner=00.
REQ-012 On entry to MATCH_OVER, winner SHALL show the player with more wins, or 11 if wins are equal.
- match_over=1, phys_tick=0, input_en=0, phys_reset=0 (final poses stay visible).
- start -> INTRO of a new match per REQ-005.
REQ-013 start SHALL be ignored in INTRO, FIGHT and KO.
- Health changes outside FIGHT tick cycles SHALL have no effect.
REQ-014 Win counters SHALL saturate at 3.
- round_no SHALL never exceed MAX_ROUNDS.

Reset
REQ-015 While reset is high, on each clk edge:
- state=IDLE; divider and all counters cleared.
- tick=0, phys_tick=0, input_en=0, phys_reset=1.
- round_time=ROUND_SECONDS, round_no=0, p1_wins=0, p2_wins=0, winner=00, match_over=0.
REQ-016 Reset asserted mid-round SHALL abort the round on the next edge with no win recorded.

Structure
REQ-017 The state encoding, winner encoding, and default timing constants SHALL live in shared package fight_pkg.
REQ-018 The divider SHALL be a sub-module, tick_divider, with parameter DIV and outputs tick and a 0..TICK_HZ-1 sub-counter.

Verification (CLK_HZ=40, TICK_HZ=20 -> tick every 2 cycles; ROUND_SECONDS=3, INTRO_TICKS=2, KO_TICKS=2)
REQ-019 Reset, then start=1 for 1 cycle -> state IDLE->INTRO, phys_reset=1, round_no=1; FIGHT entered after 2 ticks; phys_tick toggles every 2 cycles.
REQ-020 Both health=50 throughout FIGHT -> round_time 3->2->1->0 every 20 ticks; timeout -> KO, winner=11, wins unchanged.
REQ-021 p2_health set to 0 between ticks -> KO on the next tick, p1_wins=1, winner=01; phys_tick=0 during KO; INTRO with round_no=2 after 2 ticks.
REQ-022 P1 wins rounds 1 and 2 -> MATCH_OVER after round 2, match_over=1, winner=01; round 3 never starts.
REQ-023 Both health 0 on the same tick -> draw; three draws -> MATCH_OVER at round_no=3, winner=11.
REQ-024 Reset pulsed mid-FIGHT -> IDLE on the next edge, phys_reset=1, wins=0; start held during FIGHT -> no effect.
